latch_bank_wr_ctrl: RTL
=======================

// Module: latch_bank_wr_ctrl
// PURPOSE
//   Synchronous write sequencer sitting directly upstream of a bank of latrnq latch words.
//   Each latch word has its own enable E, a shared data bus D and a shared active-low clear RN.
//   Converts a single-clock valid/ready write request into a glitch-free one-hot E pulse.
//   Holds D stable across a setup window before E opens and a hold window after E closes.
//   Also sequences a bank-wide clear on RN.
// PARAMETERS
//   WIDTH      8   data bits per latch word (lat_d width)
//   NWORDS     4   latch words in bank (lat_e width); address width AW = $clog2(NWORDS), min 1
//   SETUP_CYC  1   cycles D is stable before E asserts (1..15)
//   OPEN_CYC   1   cycles E is held high (1..15)
//   HOLD_CYC   1   cycles D is held after E deasserts (1..15)
//   CLR_CYC    2   cycles lat_rn is held low for a clear (1..15)
// PORTS
//   CLK       in   1          clock, rising edge
//   RST       in   1          asynchronous active-high reset
//   wr_valid  in   1          write request
//   wr_ready  out  1          controller can accept a request
//   wr_addr   in   AW         target word index
//   wr_data   in   WIDTH      data to latch
//   clr_req   in   1          level request for a bank clear
//   lat_d     out  WIDTH      shared D bus to latches
//   lat_e     out  NWORDS     one-hot latch enables (registered outputs, no decode glitches)
//   lat_rn    out  1          active-low clear to all latches
//   busy      out  1          state != IDLE
//   err_oor   out  1          1-cycle pulse: accepted address >= NWORDS
// BEHAVIOUR
//   - Reset values (async, while RST=1): state=CLR, lat_e=0, lat_rn=0, lat_d=0, wr_ready=0, busy=1, err_oor=0.
//   - After RST deasserts: remain in CLR for CLR_CYC cycles, then enter IDLE.
//   - FSM states: IDLE, SETUP, OPEN, HOLD, CLR. All outputs are registered.
//   - IDLE: wr_ready=1, lat_e=0, lat_rn=1.
//     - If clr_req=1: go to CLR. Clear wins over a simultaneous wr_valid; that write is NOT accepted.
//     - Else, on wr_valid&wr_ready: capture addr into lat_d's companion address register, capture wr_data into lat_d, go to SETUP.
//   - SETUP: hold for SETUP_CYC cycles, then go to OPEN; the matching lat_e bit rises on entry to OPEN.
//   - OPEN: lat_e one-hot for exactly OPEN_CYC cycles, then go to HOLD; lat_e=0 on entry to HOLD.
//   - HOLD: lat_d unchanged for HOLD_CYC cycles, then go to IDLE.
//   - Accept-to-E-rise latency is SETUP_CYC+1 cycles. Back-to-back write period is 1+SETUP_CYC+OPEN_CYC+HOLD_CYC cycles.
//   - lat_d changes only on acceptance (and on reset). It never changes while any lat_e bit is 1.
//   - Out-of-range address (>= NWORDS, possible when NWORDS is not a power of 2):
//     - request is accepted and the full sequence runs with lat_e=0 throughout;
//     - err_oor pulses in the cycle after acceptance.
//   - clr_req during SETUP/OPEN/HOLD is deferred: the write completes, then IDLE takes CLR next cycle.
//   - CLR: lat_rn=0 and lat_e=0 for CLR_CYC cycles, then IDLE. clr_req still high at the end starts another CLR.
//   - RST mid-write: lat_e drops to 0 asynchronously; lat_rn goes low; the partial write is lost.
//   - Phase counter: 4 bits, reloads on every state entry, saturates at 0. No wrap.
// CONFIGURATION
//   LATWR_PARITY_EN defined:
//     - lat_d is WIDTH+1 bits; bit WIDTH = even parity (^wr_data), captured with the data.
//     - the latch bank is sized to match.
//   LATWR_PARITY_EN undefined:
//     - lat_d is WIDTH bits; no parity logic is present.
// TESTING
//   1. Reset, then release with CLR_CYC=2 -> lat_rn=0 for 2 cycles after release; wr_ready=1 on the 3rd cycle; lat_e=0 throughout.
//   2. Write addr=2 data=8'hA5, default params -> lat_d=A5 one cycle after accept; lat_e=4'b0100 for 1 cycle starting 2 cycles after accept; lat_d stays A5 one cycle after E falls; wr_ready returns 4 cycles after accept.
//   3. clr_req=1 and wr_valid=1 in the same IDLE cycle -> no acceptance; lat_rn low for CLR_CYC cycles; the write is accepted on its first IDLE cycle afterwards.
//   4. NWORDS=3, write addr=3 -> err_oor=1 for one cycle; lat_e stays 0; sequence length unchanged.
//   5. Assert RST while lat_e=4'b0001 -> lat_e=0 and lat_rn=0 in the same cycle, without waiting for an edge; FSM restarts in CLR.
//   6. LATWR_PARITY_EN defined, data=8'h07 -> lat_d[8]=1; with the macro undefined, lat_d is 8 bits.

Source files
------------

// File: rtl/latch_bank_wr_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : latch_bank_wr_ctrl_if                                             |
// | Brief  : Write-request and latch-bank bus of latch_bank_wr_ctrl.           |
// |          LATWR_PARITY_EN widens lat_d by one parity bit.                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface latch_bank_wr_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
);
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
`ifdef LATWR_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              clr_req;
  logic [DW-1:0]     lat_d;
  logic [NWORDS-1:0] lat_e;
  logic              lat_rn;
  logic              busy;
  logic              err_oor;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, lat_d, lat_e, lat_rn, busy, err_oor
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, lat_d, lat_e, lat_rn, busy, err_oor
  );
endinterface
`default_nettype wire

// File: rtl/latch_bank_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : latch_bank_wr_ctrl                                                |
// | Brief  : Sequences setup/open/hold writes and bank clears for a latch bank.|
// |          Optional macro LATWR_PARITY_EN appends even parity to lat_d.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module latch_bank_wr_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NWORDS    = 4,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  latch_bank_wr_ctrl_if.slave bus
);
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
`ifdef LATWR_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  localparam logic [3:0] c_setup_ld = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_open_ld  = 4'(OPEN_CYC - 1);
  localparam logic [3:0] c_hold_ld  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] c_clr_ld   = 4'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_OPEN  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     lat_d_q, lat_d_d;
  logic [NWORDS-1:0] lat_e_q, lat_e_d;
  logic              lat_rn_q, lat_rn_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              err_oor_q, err_oor_d;

  logic [DW-1:0]     w_wr_word;
  logic [NWORDS-1:0] w_addr_onehot;
  logic              w_addr_oor;

`ifdef LATWR_PARITY_EN
  assign w_wr_word = {^bus.wr_data, bus.wr_data};
`else
  assign w_wr_word = bus.wr_data;
`endif

  assign w_addr_oor = ({1'b0, bus.wr_addr} >= (AW+1)'(NWORDS));

  // An out-of-range captured address decodes to all zeros, so its sequence never opens a latch.
  always_comb begin
    w_addr_onehot = '0;
    for (int i = 0; i < NWORDS; i++) begin
      w_addr_onehot[i] = (addr_q == AW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    addr_d    = addr_q;
    lat_d_d   = lat_d_q;
    err_oor_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLR;
          cnt_d   = c_clr_ld;
        end else if (bus.wr_valid && wr_ready_q) begin
          state_d   = S_SETUP;
          cnt_d     = c_setup_ld;
          addr_d    = bus.wr_addr;
          lat_d_d   = w_wr_word;
          err_oor_d = w_addr_oor;
        end
      end
      S_SETUP: if (cnt_q == 4'd0) begin
        state_d = S_OPEN;
        cnt_d   = c_open_ld;
      end
      S_OPEN: if (cnt_q == 4'd0) begin
        state_d = S_HOLD;
        cnt_d   = c_hold_ld;
      end
      S_HOLD: if (cnt_q == 4'd0) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      S_CLR: if (cnt_q == 4'd0) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_CLR;
        cnt_d   = c_clr_ld;
      end
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    wr_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    lat_rn_d   = (state_d != S_CLR);
    lat_e_d    = (state_d == S_OPEN) ? w_addr_onehot : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLR;
      cnt_q      <= c_clr_ld;
      addr_q     <= '0;
      lat_d_q    <= '0;
      lat_e_q    <= '0;
      lat_rn_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      err_oor_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      lat_d_q    <= lat_d_d;
      lat_e_q    <= lat_e_d;
      lat_rn_q   <= lat_rn_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      err_oor_q  <= err_oor_d;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign bus.lat_d    = lat_d_q;
  assign bus.lat_e    = lat_e_q;
  assign bus.lat_rn   = lat_rn_q;
  assign bus.busy     = busy_q;
  assign bus.err_oor  = err_oor_q;
endmodule
`default_nettype wire
